// File: rtl/dl_path_pkg.sv
// dl_path_pkg: shared types and constants for the DL gain datapath
//   state_t    : marker-lock FSM states
//   LAT        : fixed input-to-output latency in clk cycles
//   unity_gain : gain code representing 1.0 for a given number of fractional bits
package dl_path_pkg;
  typedef enum logic {UNLOCK, LOCK} state_t;
  localparam int LAT = 3;
  function automatic logic [31:0] unity_gain(input int gfrac);
    return 32'd1 << gfrac;
  endfunction
endpackage

// File: rtl/dl_mul_rnd_sat.sv
// dl_mul_rnd_sat: signed multiply, round-half-up and symmetric saturation, 2 register stages
//   clk, rst : clock, asynchronous active-high reset
//   x_i      : signed sample (DW), registered upstream
//   g_i      : signed gain (GW, GFRAC fractional bits), registered upstream
//   y_o      : round((x*g) / 2^GFRAC) clamped to +/-(2^(DW-1)-1)
module dl_mul_rnd_sat #(
  parameter int DW    = 16,
  parameter int GW    = 16,
  parameter int GFRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [GW-1:0] g_i,
  output logic signed [DW-1:0] y_o
);
  localparam logic signed [DW+GW:0] RND  = (DW+GW+1)'(1) << (GFRAC-1);
  localparam logic signed [DW+GW:0] MAXV = {{(GW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]  YMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]  YMIN = -YMAX;
  logic signed [DW+GW-1:0] p_q;
  logic signed [DW+GW:0]   r;
  logic signed [DW-1:0]    y_d, y_q;
  // one guard bit above the product keeps the rounding add from wrapping
  always_comb begin
    r   = ($signed({p_q[DW+GW-1], p_q}) + RND) >>> GFRAC;
    y_d = r > MAXV ? YMAX : r < -MAXV ? YMIN : r[DW-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
      y_q <= '0;
    end else begin
      p_q <= x_i * g_i;
      y_q <= y_d;
    end
  end
  assign y_o = y_q;
endmodule

// File: rtl/dl_xant_gain_sync.sv
// dl_xant_gain_sync: per-antenna gain/mute on an interleaved NANT-antenna IQ stream with marker lock
//   clk, asy_rst : datapath clock, asynchronous active-high reset
//   i_fram_hd    : frame start pulse (antenna-0 slot), loads gain/mute shadows
//   i_xant_hd    : antenna-0 marker
//   i_data       : {I,Q} signed samples
//   i_gain       : per-antenna signed gains, antenna k at [k*GW +: GW]
//   i_mute       : per-antenna mute
//   i_err_clr    : clears o_sync_err
//   o_fram_hd    : i_fram_hd delayed by LAT
//   o_xant_hd    : regenerated antenna-0 marker aligned to o_data
//   o_data       : {I,Q} scaled
//   o_locked     : marker lock state
//   o_sync_err   : sticky unexpected-marker flag
module dl_xant_gain_sync
  import dl_path_pkg::*;
#(
  parameter int NANT  = 8,
  parameter int DW    = 16,
  parameter int GW    = 16,
  parameter int GFRAC = 14,
  parameter int MISS  = 2
) (
  input  logic               clk,
  input  logic               asy_rst,
  input  logic               i_fram_hd,
  input  logic               i_xant_hd,
  input  logic [2*DW-1:0]    i_data,
  input  logic [NANT*GW-1:0] i_gain,
  input  logic [NANT-1:0]    i_mute,
  input  logic               i_err_clr,
  output logic               o_fram_hd,
  output logic               o_xant_hd,
  output logic [2*DW-1:0]    o_data,
  output logic               o_locked,
  output logic               o_sync_err
);
  localparam int SW = $clog2(NANT);
  localparam int MW = $clog2(MISS + 1);
  localparam logic [GW-1:0] UNITY = GW'(unity_gain(GFRAC));
  state_t             st_q, st_d;
  logic [SW-1:0]      slot_q, slot_d, cur;
  logic [MW-1:0]      miss_q, miss_d, miss_n;
  logic               err_q, err_d, set_err, vld;
  logic [NANT*GW-1:0] gain_q, gain_d;
  logic [NANT-1:0]    mute_q, mute_d;
  logic [GW-1:0]      g_sel;
  logic signed [DW-1:0] xi_q, xq_q, yi, yq;
  logic signed [GW-1:0] g_q;
  logic [LAT-1:0]     fh_q, xh_q;
  // cur is the slot of the sample presented this cycle; slot_q is the slot expected next
  always_comb begin
    gain_d  = i_fram_hd ? i_gain : gain_q;
    mute_d  = i_fram_hd ? i_mute : mute_q;
    st_d    = st_q;
    miss_d  = miss_q;
    miss_n  = miss_q + 1'b1;
    cur     = slot_q;
    vld     = 1'b0;
    set_err = 1'b0;
    if (st_q == UNLOCK) begin
      cur = '0;
      vld = i_xant_hd;
      if (i_xant_hd) begin
        st_d   = LOCK;
        miss_d = '0;
      end
    end else begin
      vld = 1'b1;
      if (i_xant_hd) begin
        set_err = slot_q != '0;
        cur     = '0;
        miss_d  = '0;
      end else if (slot_q == '0) begin
        miss_d = miss_n;
        if (miss_n == MW'(MISS)) begin
          st_d = UNLOCK;
          vld  = 1'b0;
        end
      end
    end
    slot_d = cur == SW'(NANT-1) ? '0 : cur + 1'b1;
    err_d  = set_err | (err_q & ~i_err_clr);
    g_sel  = gain_d[cur*GW +: GW];
  end
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      st_q   <= UNLOCK;
      slot_q <= '0;
      miss_q <= '0;
      err_q  <= 1'b0;
      gain_q <= {NANT{UNITY}};
      mute_q <= '0;
    end else begin
      st_q   <= st_d;
      slot_q <= slot_d;
      miss_q <= miss_d;
      err_q  <= err_d;
      gain_q <= gain_d;
      mute_q <= mute_d;
    end
  end
  // muted or unlocked samples are zeroed by feeding a zero gain through the multiplier
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      xi_q <= '0;
      xq_q <= '0;
      g_q  <= '0;
      fh_q <= '0;
      xh_q <= '0;
    end else begin
      xi_q <= i_data[2*DW-1:DW];
      xq_q <= i_data[DW-1:0];
      g_q  <= (!vld || mute_d[cur]) ? '0 : g_sel;
      fh_q <= {fh_q[LAT-2:0], i_fram_hd};
      xh_q <= {xh_q[LAT-2:0], vld && cur == '0};
    end
  end
  dl_mul_rnd_sat #(.DW(DW), .GW(GW), .GFRAC(GFRAC)) u_i (
    .clk(clk), .rst(asy_rst), .x_i(xi_q), .g_i(g_q), .y_o(yi)
  );
  dl_mul_rnd_sat #(.DW(DW), .GW(GW), .GFRAC(GFRAC)) u_q (
    .clk(clk), .rst(asy_rst), .x_i(xq_q), .g_i(g_q), .y_o(yq)
  );
  assign o_fram_hd  = fh_q[LAT-1];
  assign o_xant_hd  = xh_q[LAT-1];
  assign o_data     = {yi, yq};
  assign o_locked   = st_q == LOCK;
  assign o_sync_err = err_q;
endmodule
